// File: rtl/raster_frame_sequencer_if.sv
// Signal bundle between the frame sequencer and its surroundings: frame timing,
// vertex BRAM read port, rasterizer handshake and framebuffer clear handshake.
interface raster_frame_sequencer_if #(
   parameter int unsigned COORD_WIDTH   = 32,
   parameter int unsigned TRI_IDX_WIDTH = 8,
   parameter int unsigned VADDR_WIDTH   = 12
);
   logic                     frame_start;
   logic [TRI_IDX_WIDTH:0]   num_tris;
   logic [VADDR_WIDTH-1:0]   mem_addr;
   logic [COORD_WIDTH-1:0]   mem_data;
   logic [9*COORD_WIDTH-1:0] tri_verts;
   logic                     raster_start;
   logic                     raster_busy;
   logic                     raster_done;
   logic                     clear_start;
   logic                     clear_done;
   logic                     busy;
   logic                     frame_done;
   logic [TRI_IDX_WIDTH-1:0] tri_idx;
   logic [31:0]              frame_cycles;

   // Sequencer side
   modport master (
      input  frame_start, num_tris, mem_data, raster_busy, raster_done, clear_done,
      output mem_addr, tri_verts, raster_start, clear_start, busy, frame_done, tri_idx,
             frame_cycles
   );

   // Frame timing / memory / rasterizer / clear engine side
   modport slave (
      output frame_start, num_tris, mem_data, raster_busy, raster_done, clear_done,
      input  mem_addr, tri_verts, raster_start, clear_start, busy, frame_done, tri_idx,
             frame_cycles
   );
endinterface

// File: rtl/raster_frame_sequencer.sv
// Frame-level controller for the triangle rasterizer: optional framebuffer clear,
// then per triangle fetch 9 vertex words from BRAM, launch the rasterizer and
// wait for it to finish. All outputs are registered.
module raster_frame_sequencer #(
   parameter int unsigned COORD_WIDTH   = 32,
   parameter int unsigned TRI_IDX_WIDTH = 8,
   parameter int unsigned VADDR_WIDTH   = 12,
   parameter int unsigned MEM_LATENCY   = 2,
   parameter bit          CLEAR_EN      = 1'b1
) (
   input logic                       clk_in,
   input logic                       rst_in,
   raster_frame_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StFetch,
      StLaunch,
      StWaitRaster,
      StNext,
      StDone
   } state_e;

   localparam int unsigned CntW = 4;
   // FETCH runs 9 address cycles plus the BRAM latency for the last word
   localparam logic [CntW-1:0]          FetchLast   = CntW'(8 + MEM_LATENCY);
   localparam logic [CntW-1:0]          LastAddrCnt = CntW'(8);
   localparam logic [CntW-1:0]          CntOne      = CntW'(1);
   localparam logic [VADDR_WIDTH-1:0]   AddrOne     = VADDR_WIDTH'(1);
   localparam logic [VADDR_WIDTH-1:0]   TriStride   = VADDR_WIDTH'(9);
   localparam logic [TRI_IDX_WIDTH-1:0] IdxOne      = TRI_IDX_WIDTH'(1);
   localparam logic [TRI_IDX_WIDTH:0]   CountOne    = (TRI_IDX_WIDTH + 1)'(1);
   localparam logic [TRI_IDX_WIDTH:0]   MaxTris     = {1'b1, {TRI_IDX_WIDTH{1'b0}}};

   state_e                   state_q, state_d;
   logic [TRI_IDX_WIDTH:0]   num_tris_q, num_tris_d;
   logic [TRI_IDX_WIDTH-1:0] tri_idx_q, tri_idx_d;
   logic [VADDR_WIDTH-1:0]   base_q, base_d;
   logic [CntW-1:0]          cnt_q, cnt_d;
   logic [VADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [9*COORD_WIDTH-1:0] tri_verts_q, tri_verts_d;
   logic                     raster_start_q, raster_start_d;
   logic                     clear_start_q, clear_start_d;
   logic                     busy_q, busy_d;
   logic                     frame_done_q, frame_done_d;
   logic [31:0]              frame_cycles_q, frame_cycles_d;

   // Next-state, datapath updates and registered-output decode
   always_comb begin
      state_d        = state_q;
      num_tris_d     = num_tris_q;
      tri_idx_d      = tri_idx_q;
      base_d         = base_q;
      cnt_d          = cnt_q;
      mem_addr_d     = mem_addr_q;
      tri_verts_d    = tri_verts_q;
      frame_cycles_d = frame_cycles_q;

      if (busy_q && (frame_cycles_q != 32'hFFFF_FFFF)) begin
         frame_cycles_d = frame_cycles_q + 32'd1;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.frame_start) begin
               num_tris_d     = (bus.num_tris > MaxTris) ? MaxTris : bus.num_tris;
               tri_idx_d      = '0;
               base_d         = '0;
               frame_cycles_d = '0;
               if (CLEAR_EN) begin
                  state_d = StClear;
               end else if (bus.num_tris == '0) begin
                  state_d = StDone;
               end else begin
                  state_d = StFetch;
               end
            end
         end
         StClear: begin
            if (bus.clear_done) begin
               state_d = (num_tris_q == '0) ? StDone : StFetch;
            end
         end
         StFetch: begin
            cnt_d = cnt_q + CntOne;
            if (cnt_q < LastAddrCnt) begin
               mem_addr_d = mem_addr_q + AddrOne;
            end
            // Word k returns MEM_LATENCY cycles after address k was presented
            for (int unsigned k = 0; k < 9; k++) begin
               if (cnt_q == CntW'(k + MEM_LATENCY)) begin
                  tri_verts_d[k*COORD_WIDTH +: COORD_WIDTH] = bus.mem_data;
               end
            end
            if (cnt_q == FetchLast) begin
               state_d = StLaunch;
            end
         end
         StLaunch: begin
            if (!bus.raster_busy) begin
               state_d = StWaitRaster;
            end
         end
         StWaitRaster: begin
            if (bus.raster_done) begin
               state_d = StNext;
            end
         end
         StNext: begin
            if (({1'b0, tri_idx_q} + CountOne) == num_tris_q) begin
               state_d = StDone;
            end else begin
               tri_idx_d = tri_idx_q + IdxOne;
               base_d    = base_q + TriStride;
               state_d   = StFetch;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Entering FETCH: restart the cycle counter and present the triangle base
      if ((state_d == StFetch) && (state_q != StFetch)) begin
         cnt_d      = '0;
         mem_addr_d = base_d;
      end

      clear_start_d  = (state_q == StIdle) && (state_d == StClear);
      raster_start_d = (state_q == StLaunch) && (state_d == StWaitRaster);
      frame_done_d   = (state_d == StDone);
      busy_d         = (state_d != StIdle) && (state_d != StDone);
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q        <= StIdle;
         num_tris_q     <= '0;
         tri_idx_q      <= '0;
         base_q         <= '0;
         cnt_q          <= '0;
         mem_addr_q     <= '0;
         tri_verts_q    <= '0;
         raster_start_q <= 1'b0;
         clear_start_q  <= 1'b0;
         busy_q         <= 1'b0;
         frame_done_q   <= 1'b0;
         frame_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         num_tris_q     <= num_tris_d;
         tri_idx_q      <= tri_idx_d;
         base_q         <= base_d;
         cnt_q          <= cnt_d;
         mem_addr_q     <= mem_addr_d;
         tri_verts_q    <= tri_verts_d;
         raster_start_q <= raster_start_d;
         clear_start_q  <= clear_start_d;
         busy_q         <= busy_d;
         frame_done_q   <= frame_done_d;
         frame_cycles_q <= frame_cycles_d;
      end
   end

   assign bus.mem_addr     = mem_addr_q;
   assign bus.tri_verts    = tri_verts_q;
   assign bus.raster_start = raster_start_q;
   assign bus.clear_start  = clear_start_q;
   assign bus.busy         = busy_q;
   assign bus.frame_done   = frame_done_q;
   assign bus.tri_idx      = tri_idx_q;
   assign bus.frame_cycles = frame_cycles_q;

endmodule

// File: tb/tb_raster_frame_sequencer.sv
// Directed bench: instance A (clear enabled, 2-cycle BRAM, word n = n) and
// instance B (no clear, 4-cycle BRAM, word n = {20'hC0DE5, n}).
module tb_raster_frame_sequencer;
   localparam int unsigned CW = 32;
   localparam int unsigned TW = 8;
   localparam int unsigned VW = 12;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   raster_frame_sequencer_if #(.COORD_WIDTH(CW), .TRI_IDX_WIDTH(TW), .VADDR_WIDTH(VW)) ifa ();
   raster_frame_sequencer_if #(.COORD_WIDTH(CW), .TRI_IDX_WIDTH(TW), .VADDR_WIDTH(VW)) ifb ();

   raster_frame_sequencer #(
      .COORD_WIDTH(CW), .TRI_IDX_WIDTH(TW), .VADDR_WIDTH(VW), .MEM_LATENCY(2), .CLEAR_EN(1'b1)
   ) dut_a (
      .clk_in(clk),
      .rst_in(rst),
      .bus   (ifa)
   );

   raster_frame_sequencer #(
      .COORD_WIDTH(CW), .TRI_IDX_WIDTH(TW), .VADDR_WIDTH(VW), .MEM_LATENCY(4), .CLEAR_EN(1'b0)
   ) dut_b (
      .clk_in(clk),
      .rst_in(rst),
      .bus   (ifb)
   );

   // BRAM models with fixed read latency
   logic [CW-1:0] pipe_a [2];
   logic [CW-1:0] pipe_b [4];

   always @(posedge clk) begin
      pipe_a[0] <= CW'(ifa.mem_addr);
      pipe_a[1] <= pipe_a[0];
   end

   always @(posedge clk) begin
      pipe_b[0] <= {20'hC0DE5, ifb.mem_addr};
      for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
   end

   assign ifa.mem_data = pipe_a[1];
   assign ifb.mem_data = pipe_b[3];

   // Pulse tallies
   int rs_a = 0, cs_a = 0, fd_a = 0, rs_b = 0, cs_b = 0;
   always @(negedge clk) begin
      if (ifa.raster_start) rs_a <= rs_a + 1;
      if (ifa.clear_start)  cs_a <= cs_a + 1;
      if (ifa.frame_done)   fd_a <= fd_a + 1;
      if (ifb.raster_start) rs_b <= rs_b + 1;
      if (ifb.clear_start)  cs_b <= cs_b + 1;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_rs_a(output int n);
      n = 0;
      while (!ifa.raster_start && n < 60) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_fd_a(output int n);
      n = 0;
      while (!ifa.frame_done && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++;
      if (ifa.mem_addr !== '0 || ifa.tri_verts !== '0 || ifa.raster_start !== 1'b0 ||
          ifa.clear_start !== 1'b0 || ifa.busy !== 1'b0 || ifa.frame_done !== 1'b0 ||
          ifa.tri_idx !== '0 || ifa.frame_cycles !== '0) begin
         bad++;
         $display("FAIL reset_a: addr=%0h busy=%b idx=%0h fc=%0h verts_or=%b want all 0",
                  ifa.mem_addr, ifa.busy, ifa.tri_idx, ifa.frame_cycles, |ifa.tri_verts);
      end
      total++;
      if (ifb.mem_addr !== '0 || ifb.tri_verts !== '0 || ifb.raster_start !== 1'b0 ||
          ifb.clear_start !== 1'b0 || ifb.busy !== 1'b0 || ifb.frame_done !== 1'b0 ||
          ifb.tri_idx !== '0 || ifb.frame_cycles !== '0) begin
         bad++;
         $display("FAIL reset_b: addr=%0h busy=%b idx=%0h fc=%0h want all 0",
                  ifb.mem_addr, ifb.busy, ifb.tri_idx, ifb.frame_cycles);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_two_tris();
      int n, rs0, cs0, fd0;
      rs0 = rs_a; cs0 = cs_a; fd0 = fd_a;
      ifa.num_tris = 9'd2;
      ifa.frame_start = 1'b1;
      tick();
      ifa.frame_start = 1'b0;
      total++;
      if (ifa.clear_start !== 1'b1 || ifa.busy !== 1'b1 || ifa.frame_cycles !== 32'd0) begin
         bad++;
         $display("FAIL two_accept: clear_start=%b busy=%b fc=%0d want 1 1 0",
                  ifa.clear_start, ifa.busy, ifa.frame_cycles);
      end
      ifa.clear_done = 1'b1;
      tick();
      ifa.clear_done = 1'b0;
      for (int t = 0; t < 2; t++) begin
         for (int k = 0; k < 9; k++) begin
            total++;
            if (ifa.mem_addr !== VW'(9*t + k)) begin
               bad++;
               $display("FAIL two_addr: got %0d want %0d", ifa.mem_addr, 9*t + k);
            end
            if (t == 1 && k == 0) begin
               total++;
               if (ifa.tri_idx !== 8'd1) begin
                  bad++;
                  $display("FAIL two_idx: got %0d want 1", ifa.tri_idx);
               end
            end
            if (k < 8) tick();
         end
         wait_rs_a(n);
         total++;
         if (n != 4) begin
            bad++;
            $display("FAIL two_fetch_len: got %0d want 4", n);
         end
         for (int k = 0; k < 9; k++) begin
            total++;
            if (ifa.tri_verts[k*CW +: CW] !== CW'(9*t + k)) begin
               bad++;
               $display("FAIL two_word: k=%0d got %0h want %0h", k,
                        ifa.tri_verts[k*CW +: CW], 9*t + k);
            end
         end
         ifa.raster_done = 1'b1;
         tick();
         ifa.raster_done = 1'b0;
         tick();
      end
      total++;
      if (ifa.frame_done !== 1'b1 || ifa.busy !== 1'b0 || ifa.tri_idx !== 8'd1 ||
          ifa.frame_cycles !== 32'd29) begin
         bad++;
         $display("FAIL two_done: fd=%b busy=%b idx=%0d fc=%0d want 1 0 1 29",
                  ifa.frame_done, ifa.busy, ifa.tri_idx, ifa.frame_cycles);
      end
      tick();
      total++;
      if (ifa.frame_done !== 1'b0 || ifa.frame_cycles !== 32'd29 || rs_a - rs0 != 2 ||
          cs_a - cs0 != 1 || fd_a - fd0 != 1) begin
         bad++;
         $display("FAIL two_pulses: fd=%b fc=%0d rs=%0d cs=%0d fdn=%0d want 0 29 2 1 1",
                  ifa.frame_done, ifa.frame_cycles, rs_a - rs0, cs_a - cs0, fd_a - fd0);
      end
   endtask

   task automatic test_zero_tris();
      int rs0;
      rs0 = rs_a;
      ifa.num_tris = 9'd0;
      ifa.frame_start = 1'b1;
      tick();
      ifa.frame_start = 1'b0;
      total++;
      if (ifa.clear_start !== 1'b1) begin
         bad++;
         $display("FAIL zero_clear: got %b want 1", ifa.clear_start);
      end
      tick();
      tick();
      ifa.clear_done = 1'b1;
      tick();
      ifa.clear_done = 1'b0;
      total++;
      if (ifa.frame_done !== 1'b1 || ifa.busy !== 1'b0 || ifa.frame_cycles !== 32'd3 ||
          ifa.mem_addr !== VW'(17)) begin
         bad++;
         $display("FAIL zero_done: fd=%b busy=%b fc=%0d addr=%0d want 1 0 3 17",
                  ifa.frame_done, ifa.busy, ifa.frame_cycles, ifa.mem_addr);
      end
      tick();
      total++;
      if (rs_a != rs0) begin
         bad++;
         $display("FAIL zero_rs: got %0d pulses want 0", rs_a - rs0);
      end
   endtask

   task automatic test_raster_busy();
      int n, early;
      ifa.num_tris = 9'd1;
      ifa.frame_start = 1'b1;
      tick();
      ifa.frame_start = 1'b0;
      ifa.clear_done = 1'b1;
      tick();
      ifa.clear_done = 1'b0;
      ifa.raster_busy = 1'b1;
      early = 0;
      for (int i = 0; i < 31; i++) begin
         tick();
         if (ifa.raster_start) early++;
      end
      total++;
      if (early != 0) begin
         bad++;
         $display("FAIL busy_hold: got %0d start pulses want 0", early);
      end
      ifa.raster_busy = 1'b0;
      tick();
      total++;
      if (ifa.raster_start !== 1'b1) begin
         bad++;
         $display("FAIL busy_release: got %b want 1", ifa.raster_start);
      end
      ifa.raster_done = 1'b1;
      tick();
      ifa.raster_done = 1'b0;
      total++;
      if (ifa.raster_start !== 1'b0) begin
         bad++;
         $display("FAIL busy_pulse_len: got %b want 0", ifa.raster_start);
      end
      wait_fd_a(n);
      total++;
      if (n != 1 || ifa.frame_cycles !== 32'd35) begin
         bad++;
         $display("FAIL busy_done: wait=%0d fc=%0d want 1 35", n, ifa.frame_cycles);
      end
      tick();
   endtask

   task automatic test_ignore();
      int n, rs0, fd0;
      rs0 = rs_a; fd0 = fd_a;
      ifa.num_tris = 9'd2;
      ifa.frame_start = 1'b1;
      tick();
      ifa.frame_start = 1'b0;
      ifa.clear_done = 1'b1;
      tick();
      ifa.clear_done = 1'b0;
      for (int t = 0; t < 2; t++) begin
         for (int k = 0; k < 9; k++) begin
            total++;
            if (ifa.mem_addr !== VW'(9*t + k)) begin
               bad++;
               $display("FAIL ign_addr: got %0d want %0d", ifa.mem_addr, 9*t + k);
            end
            if (t == 0 && k == 1) begin
               ifa.frame_start = 1'b1;
               ifa.num_tris = 9'd5;
            end
            if (t == 0 && k == 2) begin
               ifa.frame_start = 1'b0;
               ifa.raster_done = 1'b1;
            end
            if (t == 0 && k == 3) ifa.raster_done = 1'b0;
            if (k < 8) tick();
         end
         wait_rs_a(n);
         total++;
         if (n != 4) begin
            bad++;
            $display("FAIL ign_fetch_len: got %0d want 4", n);
         end
         if (t == 0) ifa.frame_start = 1'b1;
         ifa.raster_done = 1'b1;
         tick();
         ifa.raster_done = 1'b0;
         ifa.frame_start = 1'b0;
         tick();
      end
      total++;
      if (ifa.frame_done !== 1'b1 || ifa.tri_idx !== 8'd1) begin
         bad++;
         $display("FAIL ign_done: fd=%b idx=%0d want 1 1", ifa.frame_done, ifa.tri_idx);
      end
      tick();
      total++;
      if (ifa.busy !== 1'b0 || rs_a - rs0 != 2 || fd_a - fd0 != 1) begin
         bad++;
         $display("FAIL ign_count: busy=%b rs=%0d fd=%0d want 0 2 1",
                  ifa.busy, rs_a - rs0, fd_a - fd0);
      end
   endtask

   task automatic test_async_reset();
      int n;
      ifa.num_tris = 9'd2;
      ifa.frame_start = 1'b1;
      tick();
      ifa.frame_start = 1'b0;
      ifa.clear_done = 1'b1;
      tick();
      ifa.clear_done = 1'b0;
      wait_rs_a(n);
      tick();
      #2 rst = 1'b1;
      #1;
      total++;
      if (ifa.mem_addr !== '0 || ifa.tri_verts !== '0 || ifa.raster_start !== 1'b0 ||
          ifa.clear_start !== 1'b0 || ifa.busy !== 1'b0 || ifa.frame_done !== 1'b0 ||
          ifa.tri_idx !== '0 || ifa.frame_cycles !== '0) begin
         bad++;
         $display("FAIL async_rst: addr=%0h busy=%b idx=%0h fc=%0h verts_or=%b want all 0",
                  ifa.mem_addr, ifa.busy, ifa.tri_idx, ifa.frame_cycles, |ifa.tri_verts);
      end
      tick();
      rst = 1'b0;
      ifa.num_tris = 9'd1;
      ifa.frame_start = 1'b1;
      tick();
      ifa.frame_start = 1'b0;
      total++;
      if (ifa.clear_start !== 1'b1 || ifa.busy !== 1'b1) begin
         bad++;
         $display("FAIL rst_restart: clear_start=%b busy=%b want 1 1",
                  ifa.clear_start, ifa.busy);
      end
      ifa.clear_done = 1'b1;
      tick();
      ifa.clear_done = 1'b0;
      total++;
      if (ifa.mem_addr !== VW'(0)) begin
         bad++;
         $display("FAIL rst_addr0: got %0d want 0", ifa.mem_addr);
      end
      tick();
      total++;
      if (ifa.mem_addr !== VW'(1)) begin
         bad++;
         $display("FAIL rst_addr1: got %0d want 1", ifa.mem_addr);
      end
      wait_rs_a(n);
      ifa.raster_done = 1'b1;
      tick();
      ifa.raster_done = 1'b0;
      wait_fd_a(n);
      total++;
      if (n >= 200 || ifa.tri_idx !== 8'd0 || ifa.frame_cycles !== 32'd15) begin
         bad++;
         $display("FAIL rst_frame: wait=%0d idx=%0d fc=%0d want <200 0 15",
                  n, ifa.tri_idx, ifa.frame_cycles);
      end
      tick();
   endtask

   task automatic test_no_clear();
      int n, rs0, cs0;
      rs0 = rs_b; cs0 = cs_b;
      ifb.num_tris = 9'd1;
      ifb.frame_start = 1'b1;
      tick();
      ifb.frame_start = 1'b0;
      total++;
      if (ifb.busy !== 1'b1 || ifb.clear_start !== 1'b0) begin
         bad++;
         $display("FAIL nc_accept: busy=%b clear_start=%b want 1 0", ifb.busy, ifb.clear_start);
      end
      for (int k = 0; k < 9; k++) begin
         total++;
         if (ifb.mem_addr !== VW'(k)) begin
            bad++;
            $display("FAIL nc_addr: got %0d want %0d", ifb.mem_addr, k);
         end
         if (k < 8) tick();
      end
      n = 0;
      while (!ifb.raster_start && n < 60) begin
         tick();
         n++;
      end
      total++;
      if (n != 6) begin
         bad++;
         $display("FAIL nc_fetch_len: got %0d want 6", n);
      end
      for (int k = 0; k < 9; k++) begin
         total++;
         if (ifb.tri_verts[k*CW +: CW] !== {20'hC0DE5, VW'(k)}) begin
            bad++;
            $display("FAIL nc_word: k=%0d got %0h want %0h", k,
                     ifb.tri_verts[k*CW +: CW], {20'hC0DE5, VW'(k)});
         end
      end
      ifb.raster_done = 1'b1;
      tick();
      ifb.raster_done = 1'b0;
      tick();
      total++;
      if (ifb.frame_done !== 1'b1 || ifb.busy !== 1'b0 || ifb.frame_cycles !== 32'd16) begin
         bad++;
         $display("FAIL nc_done: fd=%b busy=%b fc=%0d want 1 0 16",
                  ifb.frame_done, ifb.busy, ifb.frame_cycles);
      end
      tick();
      total++;
      if (cs_b != cs0 || rs_b - rs0 != 1) begin
         bad++;
         $display("FAIL nc_pulses: cs=%0d rs=%0d want 0 1", cs_b - cs0, rs_b - rs0);
      end
   endtask

   initial begin
      rst = 1'b1;
      ifa.frame_start = 1'b0; ifa.num_tris = '0; ifa.raster_busy = 1'b0;
      ifa.raster_done = 1'b0; ifa.clear_done = 1'b0;
      ifb.frame_start = 1'b0; ifb.num_tris = '0; ifb.raster_busy = 1'b0;
      ifb.raster_done = 1'b0; ifb.clear_done = 1'b0;
      test_reset();
      test_two_tris();
      test_zero_tris();
      test_raster_busy();
      test_ignore();
      test_async_reset();
      test_no_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/raster_frame_sequencer.md
Name: raster_frame_sequencer

Overview:
Frame-level controller for the triangle rasterizer. On each frame request it optionally clears the framebuffer/depth buffer, then walks a triangle list in vertex BRAM. For each triangle it fetches the 9 vertex words, presents them to the rasterizer, pulses its start and waits for done. Sits between the top-level frame timing logic and the rasterizer, replacing the hardwired triangle constants.

Parameters:
COORD_WIDTH, 32, width of one Q16.16 vertex coordinate word
TRI_IDX_WIDTH, 8, triangle index width; at most 2**TRI_IDX_WIDTH triangles per frame
VADDR_WIDTH, 12, vertex memory address width; must hold 9*(2**TRI_IDX_WIDTH)-1
MEM_LATENCY, 2, read latency of vertex BRAM in cycles, 1..4
CLEAR_EN, 1, 1 = run framebuffer clear handshake before drawing; 0 = skip CLEAR state

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous active-high reset
frame_start  in  1  single-cycle frame request; accepted only when busy=0
num_tris  in  TRI_IDX_WIDTH+1  triangle count for the frame, sampled on accepted frame_start
mem_addr  out  VADDR_WIDTH  vertex BRAM read address
mem_data  in  COORD_WIDTH  vertex BRAM read data, valid MEM_LATENCY cycles after address
tri_verts  out  9*COORD_WIDTH  current triangle; word k at bits [k*W +: W], k = 3*vertex + axis (x,y,z)
raster_start  out  1  one-cycle start pulse to rasterizer
raster_busy  in  1  rasterizer busy
raster_done  in  1  rasterizer one-cycle done pulse
clear_start  out  1  one-cycle start pulse to framebuffer clear engine
clear_done  in  1  clear engine one-cycle done pulse
busy  out  1  high from accepted frame_start until frame_done
frame_done  out  1  one-cycle pulse when all triangles are rasterized
tri_idx  out  TRI_IDX_WIDTH  index of triangle in flight
frame_cycles  out  32  cycles spent on the last/current frame, saturating

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0: mem_addr, tri_verts, raster_start, clear_start, busy, frame_done, tri_idx, frame_cycles. Latched num_tris = 0. Fetch counters = 0.
- States: IDLE, CLEAR, FETCH, LAUNCH, WAIT_RASTER, NEXT, DONE.
- IDLE: on frame_start, latch num_tris, set busy=1, clear frame_cycles to 0 and tri_idx to 0. Next state is CLEAR if CLEAR_EN, else FETCH (or DONE if num_tris=0). frame_start while busy=1 is ignored, with no queuing.
- CLEAR: clear_start=1 in the first CLEAR cycle only. Wait for clear_done, then go to FETCH, or DONE if latched num_tris=0. clear_done arriving in the same cycle as clear_start is honoured.
- FETCH: issue addresses base, base+1, ..., base+8 on 9 consecutive cycles, where base = 9*tri_idx. Base is kept by an incrementing pointer (+9 per triangle); no multiplier. Capture mem_data into word k exactly MEM_LATENCY cycles after address k is issued. The state lasts 9+MEM_LATENCY cycles. tri_verts words update only in FETCH.
- LAUNCH: wait until raster_busy=0, then pulse raster_start for 1 cycle and go to WAIT_RASTER. tri_verts stays stable from LAUNCH through WAIT_RASTER.
- WAIT_RASTER: on raster_done go to NEXT. raster_done seen outside WAIT_RASTER is ignored.
- NEXT (1 cycle): if tri_idx+1 == latched num_tris go to DONE. Otherwise increment tri_idx, advance base by 9, go to FETCH.
- DONE (1 cycle): frame_done=1, busy=0, go to IDLE. tri_idx keeps the last triangle's value.
- frame_cycles: increments every cycle while busy=1, saturating at 32'hFFFFFFFF. It holds its value in IDLE until the next accepted frame_start.
- num_tris > 2**TRI_IDX_WIDTH is clamped to 2**TRI_IDX_WIDTH on latch.
- All outputs are registered. raster_start, clear_start and frame_done are never high for more than 1 consecutive cycle.

Test Plan:
- CLEAR_EN=1, MEM_LATENCY=2, num_tris=2, memory word n = n: clear_start pulses once; after clear_done, addresses 0..8 are issued and tri_verts word k = k; raster_start fires. After raster_done, addresses 9..17 are issued and word k = 9+k. After the second raster_done, frame_done pulses once, busy falls, tri_idx=1.
- num_tris=0, CLEAR_EN=1: clear handshake completes, then frame_done with no mem_addr activity and no raster_start; frame_cycles equals cycles from accept to DONE.
- raster_busy held high for 20 cycles on entering LAUNCH: raster_start stays 0 until the cycle after raster_busy falls, then pulses exactly once.
- frame_start re-asserted mid-frame and a spurious raster_done during FETCH: both ignored; triangle count and addresses unchanged; exactly num_tris raster_start pulses per frame.
- rst_in asserted asynchronously mid WAIT_RASTER: all outputs read 0 before the next clock edge. A following frame_start with num_tris=1 restarts at mem_addr 0.
- CLEAR_EN=0, MEM_LATENCY=4, num_tris=1: no clear_start. Data captured 4 cycles after each address, so tri_verts matches memory contents exactly. FETCH lasts 13 cycles.
